// File: rtl/cpu_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller_pkg
// Purpose  : Shared phase encodings, opcode constants and decode helpers for
//            the instruction sequencer and its strobe decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_controller_pkg;

   // Eight-phase instruction cycle; all 3-bit encodings are assigned.
   typedef enum logic [2:0] {
      PHASE_INST_ADDR  = 3'd0,
      PHASE_INST_FETCH = 3'd1,
      PHASE_INST_LOAD  = 3'd2,
      PHASE_IDLE       = 3'd3,
      PHASE_OP_ADDR    = 3'd4,
      PHASE_OP_FETCH   = 3'd5,
      PHASE_ALU_OP     = 3'd6,
      PHASE_STORE      = 3'd7
   } phase_t;

   localparam logic [2:0] OPCODE_HLT = 3'd0;
   localparam logic [2:0] OPCODE_SKZ = 3'd1;
   localparam logic [2:0] OPCODE_ADD = 3'd2;
   localparam logic [2:0] OPCODE_AND = 3'd3;
   localparam logic [2:0] OPCODE_XOR = 3'd4;
   localparam logic [2:0] OPCODE_LDA = 3'd5;
   localparam logic [2:0] OPCODE_STO = 3'd6;
   localparam logic [2:0] OPCODE_JMP = 3'd7;

   // Opcodes whose operand is read from memory and routed through the ALU.
   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OPCODE_ADD) || (op == OPCODE_AND) ||
             (op == OPCODE_XOR) || (op == OPCODE_LDA);
   endfunction

   function automatic phase_t next_phase(input phase_t ph);
      phase_t nxt;
      case (ph)
         PHASE_INST_ADDR:  nxt = PHASE_INST_FETCH;
         PHASE_INST_FETCH: nxt = PHASE_INST_LOAD;
         PHASE_INST_LOAD:  nxt = PHASE_IDLE;
         PHASE_IDLE:       nxt = PHASE_OP_ADDR;
         PHASE_OP_ADDR:    nxt = PHASE_OP_FETCH;
         PHASE_OP_FETCH:   nxt = PHASE_ALU_OP;
         PHASE_ALU_OP:     nxt = PHASE_STORE;
         default:          nxt = PHASE_INST_ADDR;
      endcase
      return nxt;
   endfunction

endpackage : cpu_controller_pkg
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_decode
// Purpose  : Purely combinational strobe decoder for the instruction
//            sequencer: (phase, opcode, zero, halted) -> nine control strobes.
// Ports    : phase, opcode, zero, halted        - decode inputs
//            sel, rd, ld_ir, inc_pc, ld_pc,
//            ld_ac, wr, data_e, halt            - control strobes
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_decode
   import cpu_controller_pkg::*;
(
   input  phase_t     phase,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       halted,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt
);

   logic w_aluop;
   logic w_hlt;
   logic w_skz;
   logic w_sto;
   logic w_jmp;

   assign w_aluop = is_aluop(opcode);
   assign w_hlt   = (opcode == OPCODE_HLT);
   assign w_skz   = (opcode == OPCODE_SKZ);
   assign w_sto   = (opcode == OPCODE_STO);
   assign w_jmp   = (opcode == OPCODE_JMP);

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (halted) begin
         // A halted CPU asserts only halt, regardless of phase.
         halt = 1'b1;
      end else begin
         case (phase)
            PHASE_INST_ADDR: begin
               sel = 1'b1;
            end
            PHASE_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PHASE_INST_LOAD, PHASE_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PHASE_OP_ADDR: begin
               inc_pc = !w_hlt;
               halt   = w_hlt;
            end
            PHASE_OP_FETCH: begin
               rd = w_aluop;
            end
            PHASE_ALU_OP: begin
               // zero only matters here: SKZ skips the next word.
               rd     = w_aluop;
               inc_pc = w_skz & zero;
               ld_pc  = w_jmp;
               data_e = w_sto;
            end
            PHASE_STORE: begin
               rd     = w_aluop;
               ld_ac  = w_aluop;
               ld_pc  = w_jmp;
               wr     = w_sto;
               data_e = w_sto;
            end
            default: begin
               sel = 1'b1;
            end
         endcase
      end
   end

endmodule : cpu_ctrl_decode
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Eight-phase instruction sequencer. Holds the phase register,
//            the sticky halted flop and the optional memory-ready stall;
//            strobes are decoded combinationally by cpu_ctrl_decode.
// Config   : CPU_CTRL_STALL_EN - adds mem_rdy; INST_FETCH (and OP_FETCH for
//            ALU opcodes) hold while mem_rdy is low.
// Ports    : clk, rst_n (async, active-low), opcode, zero, [mem_rdy]
//            sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller
   import cpu_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef CPU_CTRL_STALL_EN
   input  logic       mem_rdy,
`endif
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt
);

   phase_t r_phase;
   logic   r_halted;
   logic   w_stall;

`ifdef CPU_CTRL_STALL_EN
   assign w_stall = !mem_rdy &&
                    ((r_phase == PHASE_INST_FETCH) ||
                     ((r_phase == PHASE_OP_FETCH) && is_aluop(opcode)));
`else
   assign w_stall = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= PHASE_INST_ADDR;
         r_halted <= 1'b0;
      end else if (r_halted) begin
         r_phase  <= r_phase;
      end else if ((r_phase == PHASE_OP_ADDR) && (opcode == OPCODE_HLT)) begin
         // Phase stays parked at OP_ADDR; the halted flag masks it anyway.
         r_halted <= 1'b1;
      end else if (!w_stall) begin
         r_phase  <= next_phase(r_phase);
      end
   end

   cpu_ctrl_decode u_decode (
      .phase  (r_phase),
      .opcode (opcode),
      .zero   (zero),
      .halted (r_halted),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt)
   );

endmodule : cpu_controller
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Self-checking bench for cpu_controller against an instruction-
//            level reference model (phase counter 0..7 plus halted bit).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

   logic       clk;
   logic       rst_n;
   logic [2:0] opcode;
   logic       zero;
`ifdef CPU_CTRL_STALL_EN
   logic       mem_rdy;
   int         stall_left;
`endif
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

   int checks;
   int errors;
   int m_phase;
   bit m_halted;

   cpu_controller dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .zero   (zero),
`ifdef CPU_CTRL_STALL_EN
      .mem_rdy(mem_rdy),
`endif
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
   // for instruction step p (0 = instruction address ... 7 = store).
   function automatic logic [8:0] exp_out(int p, logic [2:0] op, logic z, bit h);
      logic [8:0] v;
      bit alu;
      alu = (op >= 3'd2) && (op <= 3'd5);
      v = '0;
      if (h) begin
         v[0] = 1'b1;
      end else begin
         case (p)
            0: v[8] = 1'b1;
            1: begin v[8] = 1'b1; v[7] = 1'b1; end
            2, 3: begin v[8] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; end
            4: begin v[5] = (op != 3'd0); v[0] = (op == 3'd0); end
            5: v[7] = alu;
            6: begin
               v[7] = alu; v[5] = (op == 3'd1) && z;
               v[4] = (op == 3'd7); v[1] = (op == 3'd6);
            end
            default: begin
               v[7] = alu; v[3] = alu; v[4] = (op == 3'd7);
               v[2] = (op == 3'd6); v[1] = (op == 3'd6);
            end
         endcase
      end
      return v;
   endfunction

   task automatic model_advance();
      bit stall;
      stall = 1'b0;
`ifdef CPU_CTRL_STALL_EN
      stall = !mem_rdy && ((m_phase == 1) ||
              ((m_phase == 5) && (opcode >= 3'd2) && (opcode <= 3'd5)));
`endif
      if (!m_halted) begin
         if ((m_phase == 4) && (opcode == 3'd0)) m_halted = 1'b1;
         else if (!stall) m_phase = (m_phase + 1) % 8;
      end
   endtask

   task automatic check(input string tag);
      logic [8:0] e;
      logic [8:0] o;
      e = exp_out(m_phase, opcode, zero, m_halted);
      o = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: step %0d opcode %0d zero %0b observed %b expected %b",
                tag, m_phase, opcode, zero, o, e);
      end
   endtask

   task automatic check_val(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock: model follows the edge, then new inputs are applied and checked.
   // Opcode may only change in steps 0..3 where the controller ignores it.
   task automatic cycle(input bit rnd, input logic [2:0] op, input logic z, input string tag);
      @(posedge clk);
      if (rst_n) model_advance();
      #1;
      if ((m_phase <= 3) && !m_halted)
         opcode = rnd ? 3'($urandom_range(7, 1)) : op;
      zero = rnd ? 1'($urandom_range(1, 0)) : z;
`ifdef CPU_CTRL_STALL_EN
      if ((m_phase == 1) && (stall_left > 0)) begin
         mem_rdy = 1'b0;
         stall_left--;
      end else begin
         mem_rdy = 1'b1;
      end
`endif
      #1 check(tag);
   endtask

   task automatic sync_to_start(input logic [2:0] op);
      for (int i = 0; i < 16 && m_phase != 0; i++) cycle(1'b0, op, 1'b0, "sync");
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z, input string tag,
                            output int inc_cnt);
      inc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, op, z, tag);
         inc_cnt += int'(inc_pc);
      end
   endtask

   initial begin
      int cnt;
      int len;
      int irdly;
      checks   = 0;
      errors   = 0;
      m_phase  = 0;
      m_halted = 1'b0;
      rst_n    = 1'b0;
      opcode   = 3'd2;
      zero     = 1'b0;
`ifdef CPU_CTRL_STALL_EN
      mem_rdy    = 1'b1;
      stall_left = 0;
`endif
      #2 check("reset_state");
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("after_release");

      // ADD with zero=0; first instruction starts from reset, so run 7 cycles
      // to complete it, then one full instruction with inc_pc count.
      for (int i = 0; i < 7; i++) cycle(1'b0, 3'd2, 1'b0, "add_first");
      run_instr(3'd2, 1'b0, "add", cnt);
      check_val("add_inc_pc_count", cnt, 1);

      run_instr(3'd1, 1'b1, "skz_z1", cnt);
      check_val("skz_zero1_inc_pc_count", cnt, 2);
      run_instr(3'd1, 1'b0, "skz_z0", cnt);
      check_val("skz_zero0_inc_pc_count", cnt, 1);
      run_instr(3'd6, 1'b0, "sto", cnt);
      run_instr(3'd7, 1'b1, "jmp", cnt);

      // Randomised instructions (no HLT) with random zero every cycle.
      for (int i = 0; i < 240; i++) cycle(1'b1, 3'd0, 1'b0, "random");

      // Asynchronous reset mid-instruction.
      sync_to_start(3'd4);
      for (int i = 0; i < 5; i++) cycle(1'b0, 3'd4, 1'b0, "pre_reset");
      #1 rst_n = 1'b0;
      m_phase  = 0;
      m_halted = 1'b0;
      #1 check("async_reset_mid");
      @(posedge clk);
      #1 check("reset_held");
      rst_n = 1'b1;
      #1 check("reset_released");

      // HLT: reaches halt in step 4, then stays halted with no sel/rd.
      for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b0, "hlt_fetch");
      check_val("hlt_halt_in_op_addr", int'(halt), 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 3'd5, 1'b1, "halted");
         cnt += int'(sel) + int'(rd);
      end
      check_val("halted_no_sel_rd", cnt, 0);
      check_val("halted_halt_high", int'(halt), 1);
      #1 rst_n = 1'b0;
      m_phase  = 0;
      m_halted = 1'b0;
      #1 check("halt_cleared_by_reset");
      rst_n  = 1'b1;
      opcode = 3'd3;
      for (int i = 0; i < 16; i++) cycle(1'b0, 3'd3, 1'b0, "post_halt");

`ifdef CPU_CTRL_STALL_EN
      // Three clocks of mem_rdy=0 in instruction fetch stretch the instruction.
      sync_to_start(3'd2);
      stall_left = 3;
      len   = 1;
      irdly = -1;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 3'd2, 1'b0, "stall");
         if (ld_ir && irdly < 0) irdly = i + 1;
         if (sel && !rd) break;
         len++;
      end
      check_val("stall_instr_len", len, 11);
      check_val("stall_ld_ir_delay", irdly, 5);
`else
      len   = 0;
      irdly = 0;
      sync_to_start(3'd2);
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 3'd2, 1'b0, "nostall");
         len++;
         if (sel && !rd) break;
         if (ld_ir && irdly == 0) irdly = len;
      end
      check_val("instr_len", len, 8);
      check_val("ld_ir_delay", irdly, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cpu_controller
`default_nettype wire
